status_array_arbiter: RTL and testbench



---
 rtl/status_array_arbiter_pkg.sv | 25 ++
 rtl/status_arb_grant.sv | 28 ++
 rtl/status_array_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_status_array_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/status_array_arbiter_pkg.sv
// Purpose    : shared widths, source encodings and FSM state type for the status array arbiter.
// Latency    : n/a (types and constants only).
// Backpressure: n/a.
package status_array_arbiter_pkg;

    // Status array geometry shared with status_array_wrapper.
    localparam int SA_ADDR_WIDTH = 3;
    localparam int SA_ROW_WIDTH  = 8;
    localparam int SA_NUM_BLOCKS = 4;

    // Source bit carried in the MSB of the wrapper-side tag.
    localparam logic SRC_LOOKUP = 1'b0;
    localparam logic SRC_UPDATE = 1'b1;

    typedef enum logic {
        S_ARB   = 1'b0,
        S_FLUSH = 1'b1
    } arb_state_t;

    // Counter width able to hold 0..max_streak (at least one bit).
    function automatic int streak_width(input int max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/status_arb_grant.sv
// Purpose    : two-way lookup/update priority; update wins unless its streak limit is reached.
// Latency    : combinational.
// Backpressure: none; grants are qualified by the caller.
// Ports: i_lk_valid/i_up_valid requester valids, i_upd_streak consecutive update grants
//        while a lookup waited, o_grant_lk/o_grant_up one-hot (or zero) grant.
module status_arb_grant
    import status_array_arbiter_pkg::*;
#(
    parameter int MAX_UPD_STREAK = 3,
    parameter int STREAK_W       = streak_width(MAX_UPD_STREAK)
) (
    input  logic                i_lk_valid,
    input  logic                i_up_valid,
    input  logic [STREAK_W-1:0] i_upd_streak,
    output logic                o_grant_lk,
    output logic                o_grant_up
);

    logic w_streak_full;

    assign w_streak_full = (i_upd_streak == STREAK_W'(MAX_UPD_STREAK));

    // Updates normally win; a lookup that has been starved for MAX_UPD_STREAK
    // update grants takes the next slot.
    assign o_grant_lk = i_lk_valid & (~i_up_valid | w_streak_full);
    assign o_grant_up = i_up_valid & ~(i_lk_valid & w_streak_full);

endmodule

// File: rtl/status_array_arbiter.sv
// Purpose    : arbitrates lookup/update access to the status array and sequences a full-array flush.
// Latency    : accepted request appears on o_sa_* one cycle later; responses routed combinationally.
// Backpressure: readies and all state advance only when i_sa_ready & ~i_halt; o_sa_* hold otherwise.
// Ports: clk/arst_n; i_halt stall; i_lk_* lookup request, o_lk_ready; i_up_* update request,
//        o_up_ready; i_flush/o_flush_done; o_sa_* registered wrapper request, i_sa_ready;
//        i_sa_* wrapper response; o_lk_rsp_* lookup response.
// Config: STATUS_ARB_FLUSH_EN enables the flush sequencer; undefined, i_flush is ignored.
module status_array_arbiter
    import status_array_arbiter_pkg::*;
#(
    parameter int TAG_WIDTH      = 1,
    parameter int MAX_UPD_STREAK = 3,
    parameter int ADDR_WIDTH     = SA_ADDR_WIDTH,
    parameter int ROW_WIDTH      = SA_ROW_WIDTH,
    parameter int NUM_BLOCKS     = SA_NUM_BLOCKS
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  i_halt,
    input  logic                  i_lk_valid,
    input  logic [ADDR_WIDTH-1:0] i_lk_addr,
    input  logic [TAG_WIDTH-1:0]  i_lk_tag,
    output logic                  o_lk_ready,
    input  logic                  i_up_valid,
    input  logic [ADDR_WIDTH-1:0] i_up_addr,
    input  logic [ROW_WIDTH-1:0]  i_up_data,
    input  logic [NUM_BLOCKS-1:0] i_up_wmask,
    output logic                  o_up_ready,
    input  logic                  i_flush,
    output logic                  o_flush_done,
    output logic [TAG_WIDTH:0]    o_sa_tag,
    output logic [ADDR_WIDTH-1:0] o_sa_addr,
    output logic [ROW_WIDTH-1:0]  o_sa_data,
    output logic                  o_sa_wen,
    output logic [NUM_BLOCKS-1:0] o_sa_wmask,
    output logic                  o_sa_valid,
    input  logic                  i_sa_ready,
    input  logic [TAG_WIDTH:0]    i_sa_tag,
    input  logic [ROW_WIDTH-1:0]  i_sa_data,
    input  logic                  i_sa_valid,
    output logic                  o_lk_rsp_valid,
    output logic [TAG_WIDTH-1:0]  o_lk_rsp_tag,
    output logic [ROW_WIDTH-1:0]  o_lk_rsp_data
);

    localparam int STREAK_W = streak_width(MAX_UPD_STREAK);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [STREAK_W-1:0]   r_upd_streak;
    logic                  w_adv;
    logic                  w_grant_lk;
    logic                  w_grant_up;
    logic                  w_flush_req;
    logic                  w_last_row;
    logic [ADDR_WIDTH-1:0] w_row_cnt;
    logic                  w_lk_ready;
    logic                  w_up_ready;
    logic                  w_done_nxt;

    logic [TAG_WIDTH:0]    w_nxt_tag;
    logic [ADDR_WIDTH-1:0] w_nxt_addr;
    logic [ROW_WIDTH-1:0]  w_nxt_data;
    logic                  w_nxt_wen;
    logic [NUM_BLOCKS-1:0] w_nxt_wmask;
    logic                  w_nxt_valid;

    logic                  r_flush_done;
    logic [TAG_WIDTH:0]    r_sa_tag;
    logic [ADDR_WIDTH-1:0] r_sa_addr;
    logic [ROW_WIDTH-1:0]  r_sa_data;
    logic                  r_sa_wen;
    logic [NUM_BLOCKS-1:0] r_sa_wmask;
    logic                  r_sa_valid;

    assign w_adv = i_sa_ready & ~i_halt;

    status_arb_grant #(
        .MAX_UPD_STREAK (MAX_UPD_STREAK),
        .STREAK_W       (STREAK_W)
    ) u_grant (
        .i_lk_valid   (i_lk_valid),
        .i_up_valid   (i_up_valid),
        .i_upd_streak (r_upd_streak),
        .o_grant_lk   (w_grant_lk),
        .o_grant_up   (w_grant_up)
    );

`ifdef STATUS_ARB_FLUSH_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = '1;

    logic                  r_flush_pend;
    logic [ADDR_WIDTH-1:0] r_row_cnt;

    // A pulse arriving this cycle already pre-empts arbitration, so it never
    // loses to a requester even before flush_pend is visible.
    assign w_flush_req = r_flush_pend | i_flush;
    assign w_row_cnt   = r_row_cnt;
    assign w_last_row  = (r_state == S_FLUSH) && (r_row_cnt == LAST_ROW);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_flush_pend <= 1'b0;
            r_row_cnt    <= '0;
        end else begin
            // The pulse is latched even while halted so a flush is never lost;
            // pulses arriving during an active flush are dropped.
            if (w_adv && (r_state == S_ARB) && w_flush_req) begin
                r_flush_pend <= 1'b0;
                r_row_cnt    <= '0;
            end else if (i_flush && (r_state == S_ARB)) begin
                r_flush_pend <= 1'b1;
            end
            if (w_adv && (r_state == S_FLUSH)) begin
                r_row_cnt <= r_row_cnt + ADDR_WIDTH'(1);
            end
        end
    end
`else
    logic w_unused_flush;

    assign w_unused_flush = i_flush;
    assign w_flush_req    = 1'b0;
    assign w_row_cnt      = '0;
    assign w_last_row     = 1'b0;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lk_ready  = 1'b0;
        w_up_ready  = 1'b0;
        w_done_nxt  = 1'b0;
        w_nxt_tag   = '0;
        w_nxt_addr  = '0;
        w_nxt_data  = '0;
        w_nxt_wen   = 1'b0;
        w_nxt_wmask = '0;
        w_nxt_valid = 1'b0;
        case (r_state)
            S_ARB: begin
                if (w_adv) begin
                    if (w_flush_req) begin
                        // Entry cycle: nothing is issued and no requester is readied.
                        w_state_nxt = S_FLUSH;
                    end else if (w_grant_lk) begin
                        w_lk_ready  = 1'b1;
                        w_nxt_tag   = {SRC_LOOKUP, i_lk_tag};
                        w_nxt_addr  = i_lk_addr;
                        w_nxt_valid = 1'b1;
                    end else if (w_grant_up) begin
                        w_up_ready  = 1'b1;
                        w_nxt_tag   = {SRC_UPDATE, {TAG_WIDTH{1'b0}}};
                        w_nxt_addr  = i_up_addr;
                        w_nxt_data  = i_up_data;
                        w_nxt_wen   = 1'b1;
                        w_nxt_wmask = i_up_wmask;
                        w_nxt_valid = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (w_adv) begin
                    w_nxt_tag   = {SRC_UPDATE, {TAG_WIDTH{1'b0}}};
                    w_nxt_addr  = w_row_cnt;
                    w_nxt_wen   = 1'b1;
                    w_nxt_wmask = '1;
                    w_nxt_valid = 1'b1;
                    if (w_last_row) begin
                        w_state_nxt = S_ARB;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_ARB;
            end
        endcase
    end

    // Streak counts update grants that made a waiting lookup wait longer.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_upd_streak <= '0;
        end else if (w_adv) begin
            if (!i_lk_valid || w_lk_ready) begin
                r_upd_streak <= '0;
            end else if (w_up_ready && (r_upd_streak != STREAK_W'(MAX_UPD_STREAK))) begin
                r_upd_streak <= r_upd_streak + STREAK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_sa_tag     <= '0;
            r_sa_addr    <= '0;
            r_sa_data    <= '0;
            r_sa_wen     <= 1'b0;
            r_sa_wmask   <= '0;
            r_sa_valid   <= 1'b0;
            r_flush_done <= 1'b0;
        end else begin
            // Done is a pulse, so it is not held across a stall.
            r_flush_done <= w_done_nxt;
            if (w_adv) begin
                r_sa_tag   <= w_nxt_tag;
                r_sa_addr  <= w_nxt_addr;
                r_sa_data  <= w_nxt_data;
                r_sa_wen   <= w_nxt_wen;
                r_sa_wmask <= w_nxt_wmask;
                r_sa_valid <= w_nxt_valid;
            end
        end
    end

    assign o_lk_ready   = w_lk_ready;
    assign o_up_ready   = w_up_ready;
    assign o_flush_done = r_flush_done;
    assign o_sa_tag     = r_sa_tag;
    assign o_sa_addr    = r_sa_addr;
    assign o_sa_data    = r_sa_data;
    assign o_sa_wen     = r_sa_wen;
    assign o_sa_wmask   = r_sa_wmask;
    assign o_sa_valid   = r_sa_valid;

    // Only lookup-sourced responses go back; update and flush writes are dropped.
    assign o_lk_rsp_valid = i_sa_valid & (i_sa_tag[TAG_WIDTH] == SRC_LOOKUP);
    assign o_lk_rsp_tag   = i_sa_tag[TAG_WIDTH-1:0];
    assign o_lk_rsp_data  = i_sa_data;

endmodule

// File: tb/tb_status_array_arbiter.sv
// Purpose    : self-checking bench for status_array_arbiter with a scoreboard on the o_sa_* port.
// Latency    : expects each accepted request on o_sa_* one cycle after acceptance.
// Backpressure: exercises i_sa_ready low, i_halt and flush pre-emption.
module tb_status_array_arbiter;

    logic       clk;
    logic       arst_n;
    logic       i_halt;
    logic       i_lk_valid;
    logic [2:0] i_lk_addr;
    logic [0:0] i_lk_tag;
    logic       o_lk_ready;
    logic       i_up_valid;
    logic [2:0] i_up_addr;
    logic [7:0] i_up_data;
    logic [3:0] i_up_wmask;
    logic       o_up_ready;
    logic       i_flush;
    logic       o_flush_done;
    logic [1:0] o_sa_tag;
    logic [2:0] o_sa_addr;
    logic [7:0] o_sa_data;
    logic       o_sa_wen;
    logic [3:0] o_sa_wmask;
    logic       o_sa_valid;
    logic       i_sa_ready;
    logic [1:0] i_sa_tag;
    logic [7:0] i_sa_data;
    logic       i_sa_valid;
    logic       o_lk_rsp_valid;
    logic [0:0] o_lk_rsp_tag;
    logic [7:0] o_lk_rsp_data;

    status_array_arbiter dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .i_halt         (i_halt),
        .i_lk_valid     (i_lk_valid),
        .i_lk_addr      (i_lk_addr),
        .i_lk_tag       (i_lk_tag),
        .o_lk_ready     (o_lk_ready),
        .i_up_valid     (i_up_valid),
        .i_up_addr      (i_up_addr),
        .i_up_data      (i_up_data),
        .i_up_wmask     (i_up_wmask),
        .o_up_ready     (o_up_ready),
        .i_flush        (i_flush),
        .o_flush_done   (o_flush_done),
        .o_sa_tag       (o_sa_tag),
        .o_sa_addr      (o_sa_addr),
        .o_sa_data      (o_sa_data),
        .o_sa_wen       (o_sa_wen),
        .o_sa_wmask     (o_sa_wmask),
        .o_sa_valid     (o_sa_valid),
        .i_sa_ready     (i_sa_ready),
        .i_sa_tag       (i_sa_tag),
        .i_sa_data      (i_sa_data),
        .i_sa_valid     (i_sa_valid),
        .o_lk_rsp_valid (o_lk_rsp_valid),
        .o_lk_rsp_tag   (o_lk_rsp_tag),
        .o_lk_rsp_data  (o_lk_rsp_data)
    );

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        logic       wen;
        logic [3:0] wmask;
        logic [1:0] tag;
        logic       done;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic loaded;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A new request is on o_sa_* only after an edge where the port advanced.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) loaded <= 1'b0;
        else         loaded <= i_sa_ready && !i_halt;
    end

    always @(negedge clk) begin
        if (loaded && o_sa_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sa_txn unexpected: addr=%0d wen=%0b tag=%0b", o_sa_addr, o_sa_wen, o_sa_tag);
            end else begin
                mon_e = sb.pop_front();
                if (o_sa_addr !== mon_e.addr || o_sa_data !== mon_e.data || o_sa_wen !== mon_e.wen ||
                    o_sa_wmask !== mon_e.wmask || o_sa_tag !== mon_e.tag || o_flush_done !== mon_e.done) begin
                    errors++;
                    $display("FAIL sa_txn actual addr=%0d data=%h wen=%0b mask=%b tag=%b done=%0b required addr=%0d data=%h wen=%0b mask=%b tag=%b done=%0b",
                             o_sa_addr, o_sa_data, o_sa_wen, o_sa_wmask, o_sa_tag, o_flush_done,
                             mon_e.addr, mon_e.data, mon_e.wen, mon_e.wmask, mon_e.tag, mon_e.done);
                end
            end
        end else if (arst_n) begin
            checks++;
            if (o_flush_done !== 1'b0) begin
                errors++;
                $display("FAIL stray_done actual=%0b required=0", o_flush_done);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] a, input logic [7:0] d, input logic w,
                        input logic [3:0] m, input logic [1:0] t, input logic dn);
        exp_t e;
        e.addr = a; e.data = d; e.wen = w; e.wmask = m; e.tag = t; e.done = dn;
        sb.push_back(e);
    endtask

    initial begin
        logic [7:0] pat;
        int         row;
        arst_n = 1'b0; i_halt = 1'b0; i_flush = 1'b0; i_sa_ready = 1'b0;
        i_lk_valid = 1'b0; i_lk_addr = '0; i_lk_tag = '0;
        i_up_valid = 1'b0; i_up_addr = '0; i_up_data = '0; i_up_wmask = '0;
        i_sa_tag = '0; i_sa_data = '0; i_sa_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", 32'(o_sa_valid), 0);
        chk("rst_addr",  32'(o_sa_addr), 0);
        chk("rst_data",  32'(o_sa_data), 0);
        chk("rst_wen",   32'(o_sa_wen), 0);
        chk("rst_wmask", 32'(o_sa_wmask), 0);
        chk("rst_tag",   32'(o_sa_tag), 0);
        chk("rst_done",  32'(o_flush_done), 0);
        chk("rst_lk_ready", 32'(o_lk_ready), 0);
        chk("rst_up_ready", 32'(o_up_ready), 0);
        @(negedge clk); arst_n = 1'b1; i_sa_ready = 1'b1;

        // Single lookup, then its response and an update response.
        @(negedge clk); i_lk_valid = 1'b1; i_lk_addr = 3'd5; i_lk_tag = 1'b1; #1;
        chk("lk_only_lk_ready", 32'(o_lk_ready), 1);
        chk("lk_only_up_ready", 32'(o_up_ready), 0);
        push(3'd5, 8'h00, 1'b0, 4'b0000, 2'b01, 1'b0);
        @(negedge clk); i_lk_valid = 1'b0;
        i_sa_valid = 1'b1; i_sa_tag = 2'b01; i_sa_data = 8'hA5; #1;
        chk("rsp_valid", 32'(o_lk_rsp_valid), 1);
        chk("rsp_tag",   32'(o_lk_rsp_tag), 1);
        chk("rsp_data",  32'(o_lk_rsp_data), 32'hA5);
        @(negedge clk); i_sa_tag = 2'b10; i_sa_data = 8'h5A; #1;
        chk("upd_rsp_dropped", 32'(o_lk_rsp_valid), 0);
        @(negedge clk); i_sa_valid = 1'b0;

        // Single update.
        i_up_valid = 1'b1; i_up_addr = 3'd2; i_up_data = 8'h3C; i_up_wmask = 4'b0101; #1;
        chk("up_only_up_ready", 32'(o_up_ready), 1);
        chk("up_only_lk_ready", 32'(o_lk_ready), 0);
        push(3'd2, 8'h3C, 1'b1, 4'b0101, 2'b10, 1'b0);
        @(negedge clk); i_up_valid = 1'b0;

        // Both valid: U,U,U,L,U,U,U,L (bit i set = lookup wins slot i).
        pat = 8'b1000_1000;
        i_lk_addr = 3'd1; i_lk_tag = 1'b0;
        i_up_addr = 3'd6; i_up_data = 8'h77; i_up_wmask = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            i_lk_valid = 1'b1; i_up_valid = 1'b1; #1;
            chk($sformatf("streak_lk_%0d", i), 32'(o_lk_ready), 32'(pat[i]));
            chk($sformatf("streak_up_%0d", i), 32'(o_up_ready), 32'(!pat[i]));
            if (pat[i]) push(3'd1, 8'h00, 1'b0, 4'b0000, 2'b00, 1'b0);
            else        push(3'd6, 8'h77, 1'b1, 4'b1111, 2'b10, 1'b0);
        end

        // Wrapper not ready for 4 cycles: no readies, last lookup (addr 1) held.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); i_sa_ready = 1'b0; #1;
            chk("stall_lk_ready", 32'(o_lk_ready), 0);
            chk("stall_up_ready", 32'(o_up_ready), 0);
            chk("stall_hold", {o_sa_valid, o_sa_wen, o_sa_addr}, {1'b1, 1'b0, 3'd1});
        end
        @(negedge clk); i_sa_ready = 1'b1; #1;
        chk("resume_up_ready", 32'(o_up_ready), 1);
        chk("resume_lk_ready", 32'(o_lk_ready), 0);
        push(3'd6, 8'h77, 1'b1, 4'b1111, 2'b10, 1'b0);
        @(negedge clk); i_lk_valid = 1'b0; i_up_valid = 1'b0;

        // Halt: no readies and outputs held (last was the update to row 6).
        i_halt = 1'b1; i_lk_valid = 1'b1; i_lk_addr = 3'd7; i_lk_tag = 1'b1; #1;
        chk("halt_lk_ready", 32'(o_lk_ready), 0);
        @(negedge clk); #1;
        chk("halt_hold", {o_sa_wen, o_sa_addr}, {1'b1, 3'd6});
        @(negedge clk); i_halt = 1'b0; #1;
        chk("unhalt_lk_ready", 32'(o_lk_ready), 1);
        push(3'd7, 8'h00, 1'b0, 4'b0000, 2'b01, 1'b0);
        @(negedge clk); i_lk_valid = 1'b0;

`ifdef STATUS_ARB_FLUSH_EN
        // Flush beats a concurrent lookup; 8 rows with a 2-cycle halt after row 3
        // and a second flush pulse mid-sequence that must be ignored.
        i_lk_valid = 1'b1; i_lk_addr = 3'd3; i_lk_tag = 1'b0; i_flush = 1'b1; #1;
        chk("flush_wins_lk", 32'(o_lk_ready), 0);
        chk("flush_wins_up", 32'(o_up_ready), 0);
        row = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            i_halt  = (k == 4 || k == 5);
            i_flush = (k == 2);
            #1;
            chk("flush_lk_ready", 32'(o_lk_ready), 0);
            if (!i_halt) begin
                push(3'(row), 8'h00, 1'b1, 4'b1111, 2'b10, row == 7);
                row++;
            end
        end
        @(negedge clk); i_halt = 1'b0; i_flush = 1'b0; #1;
        chk("post_flush_lk_ready", 32'(o_lk_ready), 1);
        push(3'd3, 8'h00, 1'b0, 4'b0000, 2'b00, 1'b0);
        @(negedge clk); i_lk_valid = 1'b0;

        // Reset when row 3 would be issued: everything clears, no done pulse.
        i_flush = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk); i_flush = 1'b0;
            push(3'(r), 8'h00, 1'b1, 4'b1111, 2'b10, 1'b0);
        end
        @(negedge clk); #2 arst_n = 1'b0; #1;
        chk("abort_valid", 32'(o_sa_valid), 0);
        chk("abort_fields", {o_sa_addr, o_sa_wen, o_sa_wmask, o_sa_tag, o_sa_data}, 0);
        chk("abort_done", 32'(o_flush_done), 0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk); i_lk_valid = 1'b1; i_lk_addr = 3'd5; i_lk_tag = 1'b1; #1;
        chk("abort_back_to_arb", 32'(o_lk_ready), 1);
        push(3'd5, 8'h00, 1'b0, 4'b0000, 2'b01, 1'b0);
        @(negedge clk); i_lk_valid = 1'b0;
`else
        // Without the flush sequencer a flush pulse has no effect.
        i_lk_valid = 1'b1; i_lk_addr = 3'd3; i_lk_tag = 1'b0; i_flush = 1'b1; #1;
        chk("flush_ignored_lk", 32'(o_lk_ready), 1);
        push(3'd3, 8'h00, 1'b0, 4'b0000, 2'b00, 1'b0);
        @(negedge clk); i_lk_valid = 1'b0; i_flush = 1'b0;
`endif

        repeat (4) @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
